// File: rtl/ami_pkg.sv
// ami_pkg -- definitions shared by the AMI write-DMA block.
//   wdma_state_t : DMA sequencer states (IDLE -> AW -> DAT -> AW | WB -> IDLE)
//   BURST_INCR   : AXI incrementing burst encoding
//   RESP_OKAY    : AXI OKAY response encoding
//   BOUND_4K     : AXI bursts may not cross this byte boundary
package ami_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_DAT  = 2'd2,
        ST_WB   = 2'd3
    } wdma_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int         BOUND_4K   = 4096;

endpackage

// File: rtl/ami_rdly.sv
// ami_rdly -- fixed-latency shift register that carries {last, valid} of each
// RAM read alongside the RAM pipeline so the write beat appears exactly when
// the read data does.
//   ACLK, ARESETn : clock, asynchronous active-low reset (clears all stages)
//   shift_in      : {last, valid} of the read issued this cycle
//   shift_out     : {last, valid} of the read issued DEPTH cycles ago
//   busy          : any valid read still travelling through the line
module ami_rdly #(
    parameter int DEPTH = 9
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [1:0] shift_in,
    output logic [1:0] shift_out,
    output logic       busy
);

    logic [1:0] stage [DEPTH];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= 2'b00;
        end else begin
            stage[0] <= shift_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign shift_out = stage[DEPTH-1];

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) busy = busy | stage[i][0];
    end

endmodule

// File: rtl/ami_wdma.sv
// ami_wdma -- write DMA: streams a block of local RAM words out as AXI write
// bursts, splitting at MAX_BL beats and at 4 KB boundaries.
//   ACLK / ARESETn           : clock, asynchronous active-low reset
//   cmd_*                    : command (ID, byte address, first RAM word, beats-1)
//   ram_re/ram_addr/ram_rdata: local RAM read port, RAM_WS cycles latency
//   usr_aw*                  : AXI write-address channel
//   usr_w*                   : AXI write-data channel; usr_wnafull throttles reads
//   usr_b*                   : AXI write-response channel (always ready)
//   done                     : one-cycle pulse when every burst has its response
//   err                      : sticky error, cleared when a command is accepted
// Build option: define AMI_WDMA_BRESP_CHK_EN to also flag non-OKAY write
// responses in err; otherwise only W-channel overflow sets err.
module ami_wdma
    import ami_pkg::*;
#(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int RAM_AW = 12,
    parameter int RAM_WS = 9,
    parameter int MAX_BL = 16
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [AXI_IW-1:0]   cmd_id,
    input  logic [AXI_AW-1:0]   cmd_addr,
    input  logic [RAM_AW-1:0]   cmd_raddr,
    input  logic [15:0]         cmd_beats,
    output logic                ram_re,
    output logic [RAM_AW-1:0]   ram_addr,
    input  logic [AXI_DW-1:0]   ram_rdata,
    output logic [AXI_IW-1:0]   usr_awid,
    output logic [AXI_AW-1:0]   usr_awaddr,
    output logic [AXI_LW-1:0]   usr_awlen,
    output logic [2:0]          usr_awsize,
    output logic [1:0]          usr_awburst,
    output logic                usr_awvalid,
    input  logic                usr_awready,
    output logic [AXI_DW-1:0]   usr_wdata,
    output logic [AXI_DW/8-1:0] usr_wstrb,
    output logic                usr_wlast,
    output logic                usr_wvalid,
    input  logic                usr_wready,
    input  logic                usr_wnafull,
    input  logic [AXI_IW-1:0]   usr_bid,
    input  logic [1:0]          usr_bresp,
    input  logic                usr_bvalid,
    output logic                usr_bready,
    output logic                done,
    output logic                err
);

    localparam int          SZ       = $clog2(AXI_DW / 8);
    localparam logic [16:0] MAX_BL_V = 17'(MAX_BL);

    wdma_state_t       state, nxt;
    logic [AXI_IW-1:0] id_r;
    logic [AXI_AW-1:0] addr_r;
    logic [16:0]       rem_r;      // beats still to be read, up to 65536
    logic [16:0]       issued_r;   // reads issued in the current burst
    logic [16:0]       ocnt_r;     // bursts issued minus responses received
    logic [16:0]       bl;
    logic [12:0]       room;
    logic [16:0]       room_beats;
    logic              cmd_hs, aw_hs, last_re, inflight, bresp_bad;
    logic [1:0]        dly_out;
    logic              b_unused;

    assign cmd_hs  = cmd_valid & cmd_ready;
    assign aw_hs   = usr_awvalid & usr_awready;
    assign last_re = ram_re && (issued_r == bl - 17'd1);

    // Burst length: remaining beats, capped by MAX_BL and by the 4 KB boundary.
    // addr_r and rem_r only move on the last read of a burst, so bl is stable
    // for the whole AW phase and the matching DAT phase.
    always_comb begin
        room       = 13'(BOUND_4K) - {1'b0, addr_r[11:0]};
        room_beats = 17'(room >> SZ);
        bl         = rem_r;
        if (bl > MAX_BL_V)   bl = MAX_BL_V;
        if (bl > room_beats) bl = room_beats;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= ST_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (cmd_hs) nxt = ST_AW;
            ST_AW:   if (aw_hs)  nxt = ST_DAT;
            // Next AW may go out while this burst's data is still in the RAM pipe.
            ST_DAT:  if (last_re) nxt = (rem_r != bl) ? ST_AW : ST_WB;
            ST_WB:   if (ocnt_r == 17'd0 && !inflight) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = (state == ST_IDLE);
        usr_awvalid = (state == ST_AW);
        ram_re      = (state == ST_DAT) && usr_wnafull && (issued_r < bl);
        done        = (state == ST_WB) && (ocnt_r == 17'd0) && !inflight;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_r     <= '0;
            addr_r   <= '0;
            ram_addr <= '0;
            rem_r    <= '0;
            issued_r <= '0;
        end else if (cmd_hs) begin
            id_r     <= cmd_id;
            addr_r   <= cmd_addr;
            ram_addr <= cmd_raddr;
            rem_r    <= {1'b0, cmd_beats} + 17'd1;
            issued_r <= '0;
        end else if (ram_re) begin
            ram_addr <= ram_addr + 1'b1;
            if (last_re) begin
                issued_r <= '0;
                addr_r   <= addr_r + (AXI_AW'(bl) << SZ);
                rem_r    <= rem_r - bl;
            end else begin
                issued_r <= issued_r + 17'd1;
            end
        end
    end

    // usr_bready is tied high, so every usr_bvalid is a received response.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ocnt_r <= '0;
        end else begin
            case ({aw_hs, usr_bvalid})
                2'b10:   ocnt_r <= ocnt_r + 17'd1;
                2'b01:   if (ocnt_r != 17'd0) ocnt_r <= ocnt_r - 17'd1;
                default: ocnt_r <= ocnt_r;
            endcase
        end
    end

`ifdef AMI_WDMA_BRESP_CHK_EN
    assign bresp_bad = usr_bvalid && (usr_bresp != RESP_OKAY);
`else
    assign bresp_bad = 1'b0;
`endif
    assign b_unused = ^{usr_bid, usr_bresp};

    // A beat offered while the W buffer cannot take it is lost; flag it.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)                                err <= 1'b0;
        else if ((usr_wvalid && !usr_wready) || bresp_bad) err <= 1'b1;
        else if (cmd_hs)                             err <= 1'b0;
    end

    ami_rdly #(
        .DEPTH     (RAM_WS)
    ) u_rdly (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .shift_in  ({last_re, ram_re}),
        .shift_out (dly_out),
        .busy      (inflight)
    );

    assign usr_wvalid  = dly_out[0];
    assign usr_wlast   = dly_out[1];
    assign usr_wdata   = ram_rdata;
    assign usr_wstrb   = '1;
    assign usr_awid    = id_r;
    assign usr_awaddr  = addr_r;
    assign usr_awlen   = AXI_LW'(bl - 17'd1);
    assign usr_awsize  = 3'(SZ);
    assign usr_awburst = BURST_INCR;
    assign usr_bready  = 1'b1;

endmodule

// File: tb/tb_ami_wdma.sv
// tb_ami_wdma -- directed bench for ami_wdma with default parameters.
// Expected AW bursts and W beats are queued when each command is issued and
// compared as the DUT produces them; a small RAM model returns a
// address-derived word RAM_WS cycles after each read.
module tb_ami_wdma;

    localparam int AXI_DW = 128;
    localparam int AXI_AW = 32;
    localparam int AXI_IW = 8;
    localparam int AXI_LW = 8;
    localparam int RAM_AW = 12;
    localparam int RAM_WS = 9;
    localparam int MAX_BL = 16;

`ifdef AMI_WDMA_BRESP_CHK_EN
    localparam logic EXP_BERR = 1'b1;
`else
    localparam logic EXP_BERR = 1'b0;
`endif

    logic                ACLK = 1'b0;
    logic                ARESETn;
    logic                cmd_valid, cmd_ready;
    logic [AXI_IW-1:0]   cmd_id;
    logic [AXI_AW-1:0]   cmd_addr;
    logic [RAM_AW-1:0]   cmd_raddr;
    logic [15:0]         cmd_beats;
    logic                ram_re;
    logic [RAM_AW-1:0]   ram_addr;
    logic [AXI_DW-1:0]   ram_rdata;
    logic [AXI_IW-1:0]   usr_awid;
    logic [AXI_AW-1:0]   usr_awaddr;
    logic [AXI_LW-1:0]   usr_awlen;
    logic [2:0]          usr_awsize;
    logic [1:0]          usr_awburst;
    logic                usr_awvalid, usr_awready;
    logic [AXI_DW-1:0]   usr_wdata;
    logic [AXI_DW/8-1:0] usr_wstrb;
    logic                usr_wlast, usr_wvalid, usr_wready, usr_wnafull;
    logic [AXI_IW-1:0]   usr_bid;
    logic [1:0]          usr_bresp;
    logic                usr_bvalid, usr_bready;
    logic                done, err;

    ami_wdma #(
        .AXI_DW(AXI_DW), .AXI_AW(AXI_AW), .AXI_IW(AXI_IW), .AXI_LW(AXI_LW),
        .RAM_AW(RAM_AW), .RAM_WS(RAM_WS), .MAX_BL(MAX_BL)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_raddr(cmd_raddr), .cmd_beats(cmd_beats),
        .ram_re(ram_re), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .usr_awid(usr_awid), .usr_awaddr(usr_awaddr), .usr_awlen(usr_awlen),
        .usr_awsize(usr_awsize), .usr_awburst(usr_awburst),
        .usr_awvalid(usr_awvalid), .usr_awready(usr_awready),
        .usr_wdata(usr_wdata), .usr_wstrb(usr_wstrb), .usr_wlast(usr_wlast),
        .usr_wvalid(usr_wvalid), .usr_wready(usr_wready), .usr_wnafull(usr_wnafull),
        .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid),
        .usr_bready(usr_bready), .done(done), .err(err)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [127:0] data; logic last; } w_t;
    aw_t aw_q[$];
    w_t  w_q[$];
    aw_t mon_aw;
    w_t  mon_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b_cycle = -10;
    int b_count = 0;
    int b_issued = 0;
    int bad_b = 0;
    int pending_b = 0;
    logic [AXI_IW-1:0] cur_id = '0;
    logic              aw_stall = 1'b0;
    logic [31:0]       aw_stall_addr = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ram_word(input logic [11:0] a);
        return {20'hD00D5, a, 20'h1234A, a, 20'hBEEF0, a, 20'h0CAFE, a};
    endfunction

    // RAM model: word for ram_addr appears RAM_WS cycles after it is presented.
    logic [11:0] apipe [RAM_WS];
    always @(posedge ACLK) begin
        apipe[0] <= ram_addr;
        for (int i = 1; i < RAM_WS; i++) apipe[i] <= apipe[i-1];
    end
    assign ram_rdata = ram_word(apipe[RAM_WS-1]);

    always @(posedge ACLK) cyc <= cyc + 1;

    // Slave side: random AW backpressure, one B per completed W burst.
    always @(posedge ACLK) begin
        #1;
        usr_awready = ($urandom_range(0, 3) != 0);
        if (usr_bvalid) begin
            usr_bvalid = 1'b0;
        end else if (pending_b > 0) begin
            pending_b--;
            b_issued++;
            usr_bresp  = (b_issued == bad_b) ? 2'b10 : 2'b00;
            usr_bid    = cur_id;
            usr_bvalid = 1'b1;
        end
    end

    // Monitor / scoreboard.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (aw_stall) begin
                chk("aw_hold_valid", 128'(usr_awvalid), 128'(1'b1));
                chk("aw_hold_addr", 128'(usr_awaddr), 128'(aw_stall_addr));
            end
            aw_stall      = usr_awvalid && !usr_awready;
            aw_stall_addr = usr_awaddr;
            if (usr_awvalid && usr_awready) begin
                chk("aw_expected", 128'(aw_q.size() != 0), 128'(1'b1));
                if (aw_q.size() != 0) begin
                    mon_aw = aw_q.pop_front();
                    chk("awaddr", 128'(usr_awaddr), 128'(mon_aw.addr));
                    chk("awlen", 128'(usr_awlen), 128'(mon_aw.len));
                    chk("awid", 128'(usr_awid), 128'(cur_id));
                    chk("awsize", 128'(usr_awsize), 128'(3'd4));
                    chk("awburst", 128'(usr_awburst), 128'(2'b01));
                end
            end
            if (usr_wvalid) begin
                chk("w_expected", 128'(w_q.size() != 0), 128'(1'b1));
                if (w_q.size() != 0) begin
                    mon_w = w_q.pop_front();
                    if (usr_wready) begin
                        chk("wdata", usr_wdata, mon_w.data);
                        chk("wlast", 128'(usr_wlast), 128'(mon_w.last));
                        chk("wstrb", 128'(usr_wstrb), 128'(16'hFFFF));
                        if (usr_wlast) pending_b++;
                    end
                end
            end
            if (usr_bvalid) begin
                b_count++;
                b_cycle = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic exp_burst(input logic [31:0] addr, input logic [11:0] raddr, input int len);
        aw_q.push_back('{addr: addr, len: 8'(len)});
        for (int i = 0; i <= len; i++)
            w_q.push_back('{data: ram_word(raddr + 12'(i)), last: (i == len)});
    endtask

    task automatic send_cmd(input logic [7:0] id, input logic [31:0] addr,
                            input logic [11:0] raddr, input logic [15:0] beats);
        int n = 0;
        b_count  = 0;
        b_issued = 0;
        cur_id   = id;
        @(posedge ACLK); #1;
        while (!cmd_ready && n < 200) begin @(posedge ACLK); #1; n++; end
        cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_raddr = raddr; cmd_beats = beats;
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        @(negedge ACLK);
        chk("cmd_ready_busy", 128'(cmd_ready), 128'(1'b0));
        chk("err_cleared", 128'(err), 128'(1'b0));
    endtask

    task automatic wait_done(input int nb, input logic exp_err);
        int  n = 0;
        logic got = 1'b0;
        while (n < 3000 && !got) begin
            @(negedge ACLK);
            n++;
            if (done) got = 1'b1;
        end
        chk("done_seen", 128'(got), 128'(1'b1));
        chk("done_after_b", 128'(cyc), 128'(b_cycle + 1));
        chk("b_count", 128'(b_count), 128'(nb));
        chk("aw_q_empty", 128'(aw_q.size()), 128'(0));
        chk("w_q_empty", 128'(w_q.size()), 128'(0));
        @(negedge ACLK);
        chk("done_pulse", 128'(done), 128'(1'b0));
        chk("err_final", 128'(err), 128'(exp_err));
        chk("cmd_ready_idle", 128'(cmd_ready), 128'(1'b1));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        chk("rst_ram_re", 128'(ram_re), 128'(1'b0));
        chk("rst_awvalid", 128'(usr_awvalid), 128'(1'b0));
        chk("rst_wvalid", 128'(usr_wvalid), 128'(1'b0));
        chk("rst_wlast", 128'(usr_wlast), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_err", 128'(err), 128'(1'b0));
        chk("rst_bready", 128'(usr_bready), 128'(1'b1));
    endtask

    initial begin
        int   n;
        logic seen;
        ARESETn = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0;
        cmd_raddr = '0; cmd_beats = '0; usr_awready = 1'b0; usr_wready = 1'b1;
        usr_wnafull = 1'b1; usr_bid = '0; usr_bresp = 2'b00; usr_bvalid = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk_reset_outputs();
        @(posedge ACLK); #1;
        ARESETn = 1'b1;

        // Single aligned 16-beat burst.
        exp_burst(32'h1000, 12'h010, 15);
        send_cmd(8'h03, 32'h1000, 12'h010, 16'd15);
        wait_done(1, 1'b0);

        // 4 KB boundary split.
        exp_burst(32'h0FC0, 12'h100, 3);
        exp_burst(32'h1000, 12'h104, 3);
        send_cmd(8'h11, 32'h0FC0, 12'h100, 16'd7);
        wait_done(2, 1'b0);

        // MAX_BL split, 40 beats.
        exp_burst(32'h2000, 12'h200, 15);
        exp_burst(32'h2100, 12'h210, 15);
        exp_burst(32'h2200, 12'h220, 7);
        send_cmd(8'h22, 32'h2000, 12'h200, 16'd39);
        wait_done(3, 1'b0);

        // Throttle by usr_wnafull mid-burst; RAM address also wraps.
        exp_burst(32'h3000, 12'hFF0, 15);
        exp_burst(32'h3100, 12'h000, 15);
        send_cmd(8'h33, 32'h3000, 12'hFF0, 16'd31);
        n = 0;
        while (n < 5) begin @(negedge ACLK); if (ram_re) n++; end
        @(posedge ACLK); #1;
        usr_wnafull = 1'b0;
        repeat (20) begin
            @(negedge ACLK);
            chk("nafull_no_re", 128'(ram_re), 128'(1'b0));
        end
        @(posedge ACLK); #1;
        usr_wnafull = 1'b1;
        wait_done(2, 1'b0);

        // Error response on the second B.
        bad_b = 2;
        exp_burst(32'h4000, 12'h300, 15);
        exp_burst(32'h4100, 12'h310, 15);
        send_cmd(8'h44, 32'h4000, 12'h300, 16'd31);
        wait_done(2, EXP_BERR);
        bad_b = 0;

        // Single-beat command; handshake clears any sticky error.
        exp_burst(32'h5000, 12'h400, 0);
        send_cmd(8'h55, 32'h5000, 12'h400, 16'd0);
        wait_done(1, 1'b0);

        // W overflow: first beat offered while the buffer refuses it.
        usr_wready = 1'b0;
        exp_burst(32'h6000, 12'h500, 3);
        send_cmd(8'h66, 32'h6000, 12'h500, 16'd3);
        n = 0; seen = 1'b0;
        while (n < 200 && !seen) begin @(negedge ACLK); n++; if (usr_wvalid) seen = 1'b1; end
        chk("ovf_beat_seen", 128'(seen), 128'(1'b1));
        @(posedge ACLK); #1;
        usr_wready = 1'b1;
        wait_done(1, 1'b1);

        // Reset in the middle of a transfer, then a clean command.
        exp_burst(32'h7000, 12'h600, 15);
        exp_burst(32'h7100, 12'h610, 15);
        send_cmd(8'h77, 32'h7000, 12'h600, 16'd31);
        n = 0;
        while (n < 3) begin @(negedge ACLK); if (ram_re) n++; end
        @(posedge ACLK); #2;
        ARESETn = 1'b0;
        @(negedge ACLK);
        chk_reset_outputs();
        aw_q.delete();
        w_q.delete();
        pending_b = 0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        exp_burst(32'h8000, 12'h020, 15);
        send_cmd(8'h88, 32'h8000, 12'h020, 16'd15);
        wait_done(1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
